// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared widths, reset PC, control-word bit map and FSM encoding for the fetch unit
package fetch_unit_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam int CW_PC_EN    = 5;
    localparam int CW_IMEM_EN  = 3;
    localparam int CW_IF_ID_EN = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - one-entry holding buffer for a fetched word that decode could not take
module fetch_skid #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         unload_i,
    input  logic         flush_i,
    input  logic [W-1:0] instr_i,
    input  logic [W-1:0] pc_i,
    output logic         full_o,
    output logic [W-1:0] instr_o,
    output logic [W-1:0] pc_o
);

    logic         full_q;
    logic [W-1:0] instr_q;
    logic [W-1:0] pc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q  <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            full_q  <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (unload_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o  = full_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch with redirect kill and IF/ID skid
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [5:0]      ctrl_wrd_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rdy_i,
    input  logic            imem_valid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            id_stall_i,
    output logic [XLEN-1:0] if_id_instr_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic            if_id_valid_o
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic            kill_q;
    logic [XLEN-1:0] if_id_instr_q;
    logic [XLEN-1:0] if_id_pc_q;
    logic            if_id_valid_q;

    logic            pc_en, imem_en, if_id_en;
    logic            hs, resp, resp_ok, to_if_id;
    logic            skid_load, skid_unload, skid_full;
    logic [XLEN-1:0] skid_instr, skid_pc;
    logic            unused_bits;

    assign pc_en    = ctrl_wrd_i[CW_PC_EN];
    assign imem_en  = ctrl_wrd_i[CW_IMEM_EN];
    assign if_id_en = ctrl_wrd_i[CW_IF_ID_EN];
    assign unused_bits = ^{ctrl_wrd_i[4], ctrl_wrd_i[2], ctrl_wrd_i[0], br_target_i[1:0]};

    assign hs       = (state_q == ST_REQ) && imem_rdy_i;
    assign resp     = (state_q == ST_WAIT) && imem_valid_i;
    assign resp_ok  = resp && !kill_q;
    assign to_if_id = !id_stall_i && if_id_en;

    // The skid is only ever filled from WAIT, and no request leaves while it is full,
    // so a live response and a full skid never compete for IF/ID.
    assign skid_load   = resp_ok && !br_taken_i && !to_if_id;
    assign skid_unload = skid_full && to_if_id && !br_taken_i;

    fetch_skid #(.W(XLEN)) u_skid (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .flush_i  (br_taken_i),
        .instr_i  (imem_rdata_i),
        .pc_i     (pc_q),
        .full_o   (skid_full),
        .instr_o  (skid_instr),
        .pc_o     (skid_pc)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            kill_q        <= 1'b0;
            if_id_instr_q <= '0;
            if_id_pc_q    <= '0;
            if_id_valid_q <= 1'b0;
        end else begin
            if (br_taken_i) begin
                pc_q <= {br_target_i[XLEN-1:2], 2'b00};
            end else if (resp_ok && pc_en) begin
                pc_q <= pc_q + XLEN'(4);
            end

            case (state_q)
                ST_IDLE: begin
                    if (imem_en && !skid_full) state_q <= ST_REQ;
                end
                ST_REQ: begin
                    if (hs) begin
                        state_q <= ST_WAIT;
                        kill_q  <= br_taken_i;
                    end else if (br_taken_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // A response coinciding with a redirect is simply dropped; no kill is left behind.
                    if (resp) begin
                        kill_q  <= 1'b0;
                        state_q <= (imem_en && !skid_load) ? ST_REQ : ST_IDLE;
                    end else if (br_taken_i) begin
                        kill_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (br_taken_i) begin
                if_id_valid_q <= 1'b0;
            end else if (to_if_id) begin
                if (resp_ok) begin
                    if_id_instr_q <= imem_rdata_i;
                    if_id_pc_q    <= pc_q;
                    if_id_valid_q <= 1'b1;
                end else if (skid_full) begin
                    if_id_instr_q <= skid_instr;
                    if_id_pc_q    <= skid_pc;
                    if_id_valid_q <= 1'b1;
                end else begin
                    if_id_valid_q <= 1'b0;
                end
            end
        end
    end

    assign imem_req_o    = (state_q == ST_REQ);
    assign imem_addr_o   = pc_q;
    assign if_id_instr_o = if_id_instr_q;
    assign if_id_pc_o    = if_id_pc_q;
    assign if_id_valid_o = if_id_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  ctrl_wrd;
    logic        imem_rdy;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        br_taken;
    logic [31:0] br_target;
    logic        id_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;

    logic        rst2;
    logic        imem_valid2;
    logic [31:0] imem_rdata2;
    logic        br_taken2;
    logic [31:0] br_target2;
    logic        id_stall2;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic [31:0] if_id_instr2;
    logic [31:0] if_id_pc2;
    logic        if_id_valid2;

    int checks   = 0;
    int failures = 0;
    logic auto_resp;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk_i(clk), .rst_i(rst), .ctrl_wrd_i(ctrl_wrd),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_rdy_i(imem_rdy),
        .imem_valid_i(imem_valid), .imem_rdata_i(imem_rdata),
        .br_taken_i(br_taken), .br_target_i(br_target), .id_stall_i(id_stall),
        .if_id_instr_o(if_id_instr), .if_id_pc_o(if_id_pc), .if_id_valid_o(if_id_valid)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk_i(clk), .rst_i(rst2), .ctrl_wrd_i(ctrl_wrd),
        .imem_req_o(imem_req2), .imem_addr_o(imem_addr2), .imem_rdy_i(imem_rdy),
        .imem_valid_i(imem_valid2), .imem_rdata_i(imem_rdata2),
        .br_taken_i(br_taken2), .br_target_i(br_target2), .id_stall_i(id_stall2),
        .if_id_instr_o(if_id_instr2), .if_id_pc_o(if_id_pc2), .if_id_valid_o(if_id_valid2)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a + 32'h1357_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory answers one cycle after a grant when auto_resp is set.
    task automatic tick();
        logic        hs;
        logic [31:0] a;
        hs = imem_req && imem_rdy;
        a  = imem_addr;
        @(posedge clk);
        #1;
        if (auto_resp) begin
            imem_valid = hs;
            imem_rdata = hs ? instr_of(a) : 32'h0;
        end
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        ctrl_wrd = 6'b101010;
        imem_rdy = 1'b1; imem_valid = 1'b0; imem_rdata = '0;
        br_taken = 1'b0; br_target = '0; id_stall = 1'b0;
        imem_valid2 = 1'b0; imem_rdata2 = '0;
        br_taken2 = 1'b0; br_target2 = '0; id_stall2 = 1'b0;
        auto_resp = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_ifid_valid", {31'b0, if_id_valid}, 32'd0);
        chk("rst_ifid_instr", if_id_instr, 32'h0);
        chk("rst_ifid_pc", if_id_pc, 32'h0);

        rst = 1'b0;
        tick();

        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                imem_rdy = 1'b0;
                repeat (3) begin
                    tick();
                    chk("norrdy_req", {31'b0, imem_req}, 32'd1);
                    chk("nordy_addr", imem_addr, 32'h4);
                end
                imem_rdy = 1'b1;
            end
            chk("seq_req", {31'b0, imem_req}, 32'd1);
            chk("seq_addr", imem_addr, 32'(4 * k));
            tick();
            chk("seq_wait_req", {31'b0, imem_req}, 32'd0);
            tick();
            chk("seq_ifid_valid", {31'b0, if_id_valid}, 32'd1);
            chk("seq_ifid_pc", if_id_pc, 32'(4 * k));
            chk("seq_ifid_instr", if_id_instr, instr_of(32'(4 * k)));
        end

        auto_resp = 1'b0;
        tick();
        chk("br_wait_req", {31'b0, imem_req}, 32'd0);
        br_taken = 1'b1; br_target = 32'h0000_0103;
        tick();
        br_taken = 1'b0; br_target = '0;
        chk("br_ifid_valid", {31'b0, if_id_valid}, 32'd0);
        chk("br_req_low", {31'b0, imem_req}, 32'd0);
        imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_valid = 1'b0; imem_rdata = '0;
        auto_resp = 1'b1;
        chk("kill_ifid_valid", {31'b0, if_id_valid}, 32'd0);
        chk("br_new_req", {31'b0, imem_req}, 32'd1);
        chk("br_new_addr", imem_addr, 32'h100);
        tick();
        tick();
        chk("br_ifid_pc", if_id_pc, 32'h100);
        chk("br_ifid_instr", if_id_instr, instr_of(32'h100));
        chk("br_next_addr", imem_addr, 32'h104);

        id_stall = 1'b1;
        repeat (4) begin
            tick();
            chk("stall_req", {31'b0, imem_req}, 32'd0);
            chk("stall_hold_pc", if_id_pc, 32'h100);
            chk("stall_hold_valid", {31'b0, if_id_valid}, 32'd1);
        end
        id_stall = 1'b0;
        tick();
        chk("skid_ifid_pc", if_id_pc, 32'h104);
        chk("skid_ifid_instr", if_id_instr, instr_of(32'h104));
        chk("skid_ifid_valid", {31'b0, if_id_valid}, 32'd1);
        chk("skid_req", {31'b0, imem_req}, 32'd0);
        tick();
        chk("post_skid_req", {31'b0, imem_req}, 32'd1);
        chk("post_skid_addr", imem_addr, 32'h108);
        chk("post_skid_bubble", {31'b0, if_id_valid}, 32'd0);

        tick();
        auto_resp = 1'b0;
        imem_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_req", {31'b0, imem_req}, 32'd0);
        chk("midrst_addr", imem_addr, 32'h0);
        chk("midrst_ifid_valid", {31'b0, if_id_valid}, 32'd0);
        tick();
        rst = 1'b0;
        imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_valid = 1'b0; imem_rdata = '0;
        auto_resp = 1'b1;
        chk("stale_ifid_valid", {31'b0, if_id_valid}, 32'd0);
        chk("rel_req", {31'b0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'h0);
        tick();
        tick();
        chk("rel_ifid_pc", if_id_pc, 32'h0);
        chk("rel_ifid_instr", if_id_instr, instr_of(32'h0));

        rst2 = 1'b0;
        @(posedge clk); #1;
        chk("wrap_req", {31'b0, imem_req2}, 32'd1);
        chk("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        imem_valid2 = 1'b1; imem_rdata2 = 32'h0000_0013;
        @(posedge clk); #1;
        imem_valid2 = 1'b0;
        chk("wrap_addr1", imem_addr2, 32'h0);
        chk("wrap_ifid_pc", if_id_pc2, 32'hFFFF_FFFC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
